mem_serial_host: RTL and testbench

MEM_SERIAL_HOST -- requirements
Module: mem_serial_host

---
 rtl/mem_serial_host.sv | 132 +++++++++++++
 tb/tb_mem_serial_host.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_serial_host.sv
// mem_serial_host: serialises a 32-bit address (and write data) MSB-first to a responder and waits for completion
module mem_serial_host #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sdo,
  output logic        shift_en,
  output logic        transaction_done,
  output logic        read_write,
  input  logic        read_data,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, ADDR_SHIFT, ADDR_GAP, DATA_SHIFT, DATA_GAP, WR_WAIT, RD_WAIT, DONE} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, field_d;
  logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        sdo_q, sdo_d, shift_en_q, shift_en_d, transaction_done_q, transaction_done_d;
  logic        read_write_q, read_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign sdo              = sdo_q;
  assign shift_en         = shift_en_q;
  assign transaction_done = transaction_done_q;
  assign read_write       = read_write_q;
  // state, counters and latched request; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end
  // next state: 8 shift cycles + 1 gap per byte, 4 bytes per field, then the wait phase
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = ADDR_SHIFT;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      ADDR_SHIFT, DATA_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = state_q == ADDR_SHIFT ? ADDR_GAP : DATA_GAP;
      end
      ADDR_GAP: begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        state_d    = byte_cnt_q != 2'd3 ? ADDR_SHIFT : read_write_q ? DATA_SHIFT : RD_WAIT;
        wait_cnt_d = byte_cnt_q == 2'd3 && !read_write_q ? 8'd1 : wait_cnt_q;
      end
      DATA_GAP: begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        state_d    = byte_cnt_q == 2'd3 ? WR_WAIT : DATA_SHIFT;
        wait_cnt_d = byte_cnt_q == 2'd3 ? 8'd1 : wait_cnt_q;
      end
      WR_WAIT: begin
        state_d    = wait_cnt_q == 8'd2 ? DONE : WR_WAIT;
        wait_cnt_d = wait_cnt_q == 8'd2 ? 8'd0 : wait_cnt_q + 8'd1;
      end
      RD_WAIT: begin
        state_d    = read_data || wait_cnt_q == TO ? DONE : RD_WAIT;
        wait_cnt_d = read_data || wait_cnt_q == TO ? 8'd0 : wait_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are computed from the next state so that the registered copies line up with the state
  always_comb begin
    field_d            = state_d == DATA_SHIFT ? wdata_d : addr_d;
    shift_en_d         = state_d == ADDR_SHIFT || state_d == DATA_SHIFT;
    sdo_d              = shift_en_d ? field_d[{~byte_cnt_d, ~bit_cnt_d}] : 1'b0;
    transaction_done_d = state_d == ADDR_GAP || state_d == DATA_GAP;
    req_ready_d        = state_d == IDLE;
    rsp_valid_d        = state_d == DONE;
    rsp_err_d          = state_q == RD_WAIT && state_d == DONE && !read_data;
    rsp_rdata_d        = state_q == RD_WAIT && read_data ? mem_rdata : rsp_rdata_q;
    read_write_d       = state_d == IDLE ? 1'b0 : state_q == IDLE ? req_rw : read_write_q;
  end
  // output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q        <= 1'b1;
      rsp_valid_q        <= 1'b0;
      rsp_err_q          <= 1'b0;
      rsp_rdata_q        <= '0;
      sdo_q              <= 1'b0;
      shift_en_q         <= 1'b0;
      transaction_done_q <= 1'b0;
      read_write_q       <= 1'b0;
    end else begin
      req_ready_q        <= req_ready_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_err_q          <= rsp_err_d;
      rsp_rdata_q        <= rsp_rdata_d;
      sdo_q              <= sdo_d;
      shift_en_q         <= shift_en_d;
      transaction_done_q <= transaction_done_d;
      read_write_q       <= read_write_d;
    end
  end
endmodule

// File: tb/tb_mem_serial_host.sv
// tb_mem_serial_host: directed transactions checked against a queue of expected serial bits and responses
module tb_mem_serial_host;
  localparam int TO = 16;
  logic        clk = 0, reset_n = 0, req_valid = 0, req_rw = 0, read_data = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic        req_ready, rsp_valid, rsp_err, sdo, shift_en, transaction_done, read_write;
  logic [31:0] rsp_rdata;
  int          tests = 0, fails = 0;
  typedef struct {int cyc; logic err; logic [31:0] rdata;} rsp_t;
  bit          exp_bits[$];
  rsp_t        exp_rsp[$];
  logic [31:0] last_rdata = 0;

  mem_serial_host #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .sdo(sdo), .shift_en(shift_en), .transaction_done(transaction_done),
    .read_write(read_write), .read_data(read_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_sdo"}, sdo, 0);
    chk({tag, "_shift_en"}, shift_en, 0);
    chk({tag, "_tdone"}, transaction_done, 0);
    chk({tag, "_rw"}, read_write, 0);
  endtask

  // one transaction starting in an IDLE cycle (cycle 0 = acceptance)
  task automatic txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata, input int rd_at,
                     input logic [31:0] mdata, input bit hold, input bit stray);
    int cyc = 0, nshift = 0, ndone = 0, first_shift = 0;
    bit got = 0, bad_zero = 0, bad_rw = 0;
    bit ok_rd;
    rsp_t e, r;
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_rw = rw; req_addr = addr; req_wdata = wdata;
    for (int i = 31; i >= 0; i--) exp_bits.push_back(addr[i]);
    if (rw) for (int i = 31; i >= 0; i--) exp_bits.push_back(wdata[i]);
    ok_rd = !rw && rd_at >= 37 && rd_at <= 36 + TO;
    e.cyc = rw ? 75 : ok_rd ? rd_at + 1 : 36 + TO + 1;
    e.err = !rw && !ok_rd;
    e.rdata = ok_rd ? mdata : last_rdata;
    last_rdata = e.rdata;
    exp_rsp.push_back(e);
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        req_valid = hold; req_rw = ~rw; req_addr = ~addr; req_wdata = ~wdata;
      end
      if (shift_en) begin
        nshift++;
        if (first_shift == 0) first_shift = cyc;
        if (exp_bits.size() > 0) chk($sformatf("sdo_bit%0d", nshift), sdo, exp_bits.pop_front());
      end else if (sdo !== 1'b0) bad_zero = 1;
      if (transaction_done) ndone++;
      if (read_write !== rw) bad_rw = 1;
      if (rsp_valid) begin
        got = 1;
        r = exp_rsp.pop_front();
        chk("rsp_cycle", cyc, r.cyc);
        chk("rsp_err", rsp_err, r.err);
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("ready_in_done", req_ready, 0);
      end
      read_data = (cyc == rd_at) || (stray && cyc >= 3 && cyc <= 5);
      mem_rdata = cyc == rd_at ? mdata : 32'hDEADBEEF;
    end
    read_data = 0;
    chk("rsp_seen", got, 1);
    chk("shift_count", nshift, rw ? 64 : 32);
    chk("tdone_count", ndone, rw ? 8 : 4);
    chk("first_shift_cycle", first_shift, 1);
    chk("sdo_zero_when_idle", bad_zero, 0);
    chk("rw_held", bad_rw, 0);
    chk("bits_left", exp_bits.size(), 0);
    exp_bits.delete();
    tick();
    chk("ready_after_done", req_ready, 1);
    chk("rsp_valid_one_cycle", rsp_valid, 0);
    chk("rw_idle", read_write, 0);
  endtask

  initial begin
    int early = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1;
    tick();
    txn(1, 32'h12345678, 32'hCAFEF00D, -1, 0, 0, 0);
    txn(0, 32'h00000010, 0, 40, 32'hA5A5A5A5, 0, 0);
    txn(0, 32'h00000020, 0, -1, 32'h11111111, 0, 0);
    txn(0, 32'h00000030, 0, 36 + TO, 32'h5A5A1234, 0, 0);
    // abort a write in data byte 2 with an asynchronous reset pulse
    req_valid = 1; req_rw = 1; req_addr = 32'h0F0F0F0F; req_wdata = 32'h33CC33CC;
    for (int c = 1; c <= 58; c++) begin
      tick();
      if (c == 1) req_valid = 0;
      if (rsp_valid) early++;
    end
    chk("abort_in_shift", shift_en, 1);
    reset_n = 0;
    #1;
    chk_reset_vals("async_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) early++;
    end
    reset_n = 1;
    tick();
    if (rsp_valid) early++;
    chk("no_rsp_after_abort", early, 0);
    last_rdata = 0;
    txn(1, 32'h89ABCDEF, 32'h01234567, -1, 0, 0, 0);
    txn(1, 32'hFFFF0000, 32'h0000FFFF, -1, 0, 1, 1);
    txn(1, 32'h80000001, 32'h7FFFFFFE, -1, 0, 1, 0);
    txn(0, 32'hAAAA5555, 0, 37, 32'h13579BDF, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
